led_seq_ctrl: RTL
=================

# led_seq_ctrl

- Command-driven controller for the dynamic LED colour datapath, which steps its 3-bit colour one position per cycle its `button` input is high (001→010→…→110→001).
- Owns the datapath's `button` input and turns host commands into correctly timed step pulses:
  - free-run at a programmable rate;
  - single step;
  - seek to a target colour.
- Reads back the datapath's `colour` output to close the seek loop, and reports completion or error.

## Interface
Parameters:
- `RATE_W`, 8: width of the step-period field.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low; all state returns to reset values immediately.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  00 STOP, 01 RUN, 10 STEP, 11 SEEK.
- `cmd_target`  in  3  SEEK target colour; legal values are 001–110 only.
- `cmd_rate`  in  RATE_W  idle cycles between steps.
- `colour`  in  3  current colour, fed back from the LED datapath.
- `button`  out  1  step request to the LED datapath; registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse: command completed.
- `err`  out  1  one-cycle pulse: command aborted.

## Operation
- **Handshake.** A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - `cmd_ready` = state is IDLE or RUN.
  - `cmd_op`, `cmd_target` and `cmd_rate` are latched on acceptance; later changes are ignored.
- **States:** IDLE, RUN, STEP, SEEK_CHK, SEEK_WAIT.
- **IDLE**
  - STOP → stay IDLE, `done` pulse.
  - RUN → RUN, counter cleared.
  - STEP → STEP.
  - SEEK with legal target → SEEK_CHK.
  - SEEK with target 000 or 111 → stay IDLE, `err` pulse, no `button` pulse.
- **RUN**
  - Counter increments each cycle.
  - When counter == rate: `button` high for one cycle, counter clears.
  - Period is rate+1 cycles; rate=0 gives `button` continuously high.
  - STOP → IDLE, `done` pulse.
  - RUN → counter restarts with the new rate.
  - STEP or SEEK → behave as if issued from IDLE; the run is abandoned without `done`.
- **STEP**
  - `button` high for exactly one cycle.
  - Then IDLE, with `done` in the following cycle.
- **SEEK_CHK**
  - If `colour == target` → IDLE, `done` pulse.
  - Else if the pulse count == 6 → IDLE, `err` pulse. This covers a datapath stuck or outside 001–110.
  - Otherwise `button` goes high, the pulse count increments, and the state moves to SEEK_WAIT.
- **SEEK_WAIT**
  - Lasts rate+1 cycles; `button` is high only in the first.
  - Then SEEK_CHK.
  - This guarantees `colour` has settled before each compare, so a seek never overshoots.
- **Output rules**
  - `done` and `err` are mutually exclusive; at most one pulse per accepted command.
- **Reset values:**
  - state IDLE;
  - `button` 0, `busy` 0, `done` 0, `err` 0;
  - `cmd_ready` 1;
  - counters 0.
- **Reset mid-operation** aborts the command without `done` or `err`.

## Timing
- Accept edge = E.
- STEP:
  - `button` high in cycle E+1;
  - `colour` changes at edge E+2;
  - `done` high in cycle E+2.
- SEEK:
  - first compare in cycle E+1;
  - each step costs rate+2 cycles;
  - worst-case completion is 1 + 5·(rate+2) cycles after E.
- SEEK already at target: `done` in cycle E+2, no `button` pulse.
- RUN: first `button` pulse in cycle E+1+rate.
- STOP accepted at E: `button` low from cycle E+1.

## Structure
- **Package `led_seq_pkg`:**
  - `op_t` (STOP/RUN/STEP/SEEK);
  - `state_t`;
  - `COLOUR_MIN = 3'b001`, `COLOUR_MAX = 3'b110`;
  - `SEEK_MAX_STEPS = 6`.
- **Sub-module `step_timer`:**
  - RATE_W-bit counter with `clear`, `enable`, and a terminal-count output (count == rate);
  - shared by RUN and SEEK_WAIT.

## Test plan
- Bench instantiates this block driving the LED datapath, with `colour` fed back.
- Reset held, then `rst_n` 0→1 → `button`=0, `busy`=0, `cmd_ready`=1, datapath `colour`=001.
- STEP from 001 → exactly one `button` cycle, `colour`=010, `done` pulse in cycle E+2, `busy` low afterwards.
- RUN with rate=2 for 20 cycles, then STOP → `button` high every 3rd cycle, `colour` sequence 001,010,…,110,001 wraps correctly, one `done` at STOP.
- SEEK target 101 from 010, rate=0:
  - 3 `button` pulses, each separated by one low cycle;
  - `colour` ends at 101;
  - `done` once, no overshoot.
- SEEK target 111 → immediate `err`, no `button`. SEEK target equal to current `colour` → `done` with zero pulses.
- Force `colour` stuck at 000 during SEEK 011 → 6 pulses then `err`.
- Assert `rst_n` low mid-RUN → outputs return to reset values asynchronously, no `done` or `err`.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequence controller.
package led_seq_pkg;

    // Host command opcodes, encoded as they arrive on cmd_op.
    typedef enum logic [1:0] {
        OP_STOP = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_SEEK = 2'b11
    } op_t;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_SEEK_CHK  = 3'd3,
        ST_SEEK_WAIT = 3'd4
    } state_t;

    // The datapath only ever cycles through these colours.
    localparam logic [2:0] COLOUR_MIN = 3'b001;
    localparam logic [2:0] COLOUR_MAX = 3'b110;

    // Enough pulses to visit every legal colour once; more means the datapath is broken.
    localparam int unsigned SEEK_MAX_STEPS = 6;

    // True when a colour lies inside the datapath's legal range.
    function automatic logic colour_legal(input logic [2:0] c);
        return (c >= COLOUR_MIN) && (c <= COLOUR_MAX);
    endfunction

endpackage

// File: rtl/led_seq_ctrl_step_timer.sv
// Step-period counter shared by free-run and seek pacing.
// o_tc is high while the count equals the rate; o_pre is high when the count
// will equal the rate after the next edge, which lets the registered button
// line up with the terminal count.
module led_seq_ctrl_step_timer #(
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_tc,
    output logic              o_pre
);

    logic [RATE_W-1:0] r_cnt;

    assign o_tc  = (r_cnt == i_rate);
    // With rate 0 every cycle is terminal, so the next one always is too.
    assign o_pre = (i_rate == '0) || (r_cnt == (i_rate - 1'b1));

    // Count up while enabled, wrapping to zero at the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_tc ? '0 : (r_cnt + 1'b1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Command-driven step controller for the LED colour datapath: free-run,
// single step and closed-loop seek, with done/err completion pulses.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_target,
    input  logic [RATE_W-1:0] cmd_rate,
    input  logic [2:0]        colour,
    output logic              button,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state, w_state_next;
    logic [RATE_W-1:0] r_rate, w_rate_next;
    logic [2:0]        r_target, w_target_next;
    logic [2:0]        r_pulses, w_pulses_next;
    logic              r_button, w_button_next;
    logic              r_done, w_done_next;
    logic              r_err, w_err_next;

    logic w_accept;
    logic w_tmr_clear;
    logic w_tmr_enable;
    logic w_tmr_tc;
    logic w_tmr_pre;

    assign cmd_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign busy      = (r_state != ST_IDLE);
    assign button    = r_button;
    assign done      = r_done;
    assign err       = r_err;
    assign w_accept  = cmd_valid && cmd_ready;

    led_seq_ctrl_step_timer #(
        .RATE_W (RATE_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_enable),
        .i_rate   (r_rate),
        .o_tc     (w_tmr_tc),
        .o_pre    (w_tmr_pre)
    );

    // State, latched command fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rate   <= '0;
            r_target <= '0;
            r_pulses <= '0;
            r_button <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rate   <= w_rate_next;
            r_target <= w_target_next;
            r_pulses <= w_pulses_next;
            r_button <= w_button_next;
            r_done   <= w_done_next;
            r_err    <= w_err_next;
        end
    end

    // Next-state and next-output logic; a newly accepted command overrides
    // whatever the current state would have done this cycle.
    always_comb begin
        w_state_next  = r_state;
        w_rate_next   = r_rate;
        w_target_next = r_target;
        w_pulses_next = r_pulses;
        w_button_next = 1'b0;
        w_done_next   = 1'b0;
        w_err_next    = 1'b0;
        w_tmr_clear   = 1'b0;
        w_tmr_enable  = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                w_tmr_enable  = 1'b1;
                w_button_next = w_tmr_pre;
            end
            ST_STEP: begin
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
            end
            ST_SEEK_CHK: begin
                if (colour == r_target) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else if (r_pulses == 3'(SEEK_MAX_STEPS)) begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b1;
                end else begin
                    w_button_next = 1'b1;
                    w_pulses_next = r_pulses + 3'd1;
                    w_tmr_clear   = 1'b1;
                    w_state_next  = ST_SEEK_WAIT;
                end
            end
            ST_SEEK_WAIT: begin
                w_tmr_enable = 1'b1;
                if (w_tmr_tc) begin
                    w_state_next = ST_SEEK_CHK;
                end
            end
            default: begin
            end
        endcase

        if (w_accept) begin
            w_rate_next   = cmd_rate;
            w_target_next = cmd_target;
            w_tmr_clear   = 1'b1;
            w_tmr_enable  = 1'b0;
            w_button_next = 1'b0;
            w_done_next   = 1'b0;
            w_err_next    = 1'b0;
            unique case (op_t'(cmd_op))
                OP_STOP: begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
                OP_RUN: begin
                    w_state_next  = ST_RUN;
                    // Rate 0 means the button is held high from the very next cycle.
                    w_button_next = (cmd_rate == '0);
                end
                OP_STEP: begin
                    w_state_next  = ST_STEP;
                    w_button_next = 1'b1;
                end
                OP_SEEK: begin
                    if (colour_legal(cmd_target)) begin
                        w_state_next  = ST_SEEK_CHK;
                        w_pulses_next = 3'd0;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_err_next   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
